// File: rtl/core_pkg.sv
// Shared types and constants for the memory access unit.
package core_pkg;

  localparam int DATA_W            = 32;
  localparam int ADR_W             = 5;
  localparam int MAU_MEM_DEPTH_DEF = 16;
  localparam int MAU_TIMEOUT_DEF   = 8;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    WR_ISSUE,
    RESP
  } mau_state_t;

  // True when a word address falls inside the populated data memory.
  function automatic logic adr_in_range(input logic [ADR_W-1:0] adr,
                                        input int unsigned      depth);
    return 32'(adr) < depth;
  endfunction

endpackage

// File: rtl/mau_timeout_cnt.sv
// Saturating wait-cycle counter; flags the cycle whose increment reaches TIMEOUT.
module mau_timeout_cnt #(
  parameter int TIMEOUT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_reg;

  // Count enabled cycles, holding at TIMEOUT rather than wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      cnt_reg <= '0;
    end else if (enable && (cnt_reg != CNT_W'(TIMEOUT))) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  // Expiry is reported on the enabled cycle that brings the count to TIMEOUT,
  // so exactly TIMEOUT waiting cycles elapse before the error response.
  assign expired = enable && (cnt_reg >= CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store unit between execute, data memory and writeback.
module mem_access_unit
  import core_pkg::*;
#(
  parameter int MEM_DEPTH = MAU_MEM_DEPTH_DEF,
  parameter int TIMEOUT   = MAU_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADR_W-1:0]  req_adr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [ADR_W-1:0]  req_rd,
  output logic              mem_rd_en,
  output logic [ADR_W-1:0]  mem_adr,
  output logic              mem_we,
  output logic [ADR_W-1:0]  mem_wadr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [DATA_W-1:0] wb_data,
  output logic [ADR_W-1:0]  wb_rd,
  output logic              wb_err
);

  mau_state_t        state_reg, state_next;
  logic [ADR_W-1:0]  adr_reg, adr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic [ADR_W-1:0]  rd_reg, rd_next;
  logic [DATA_W-1:0] wb_data_reg, wb_data_next;
  logic [ADR_W-1:0]  wb_rd_reg, wb_rd_next;
  logic              wb_err_reg, wb_err_next;
  logic              cnt_clear, cnt_en, cnt_expired;

  mau_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (cnt_clear),
    .enable  (cnt_en),
    .expired (cnt_expired)
  );

  // State and operand/response registers; reset drops any op in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      adr_reg     <= '0;
      wdata_reg   <= '0;
      rd_reg      <= '0;
      wb_data_reg <= '0;
      wb_rd_reg   <= '0;
      wb_err_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      adr_reg     <= adr_next;
      wdata_reg   <= wdata_next;
      rd_reg      <= rd_next;
      wb_data_reg <= wb_data_next;
      wb_rd_reg   <= wb_rd_next;
      wb_err_reg  <= wb_err_next;
    end
  end

  // Next-state logic: accept, issue, wait for data or timeout, respond.
  always_comb begin
    state_next   = state_reg;
    adr_next     = adr_reg;
    wdata_next   = wdata_reg;
    rd_next      = rd_reg;
    wb_data_next = wb_data_reg;
    wb_rd_next   = wb_rd_reg;
    wb_err_next  = wb_err_reg;
    cnt_clear    = 1'b0;
    cnt_en       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          adr_next   = req_adr;
          wdata_next = req_wdata;
          rd_next    = req_rd;
          if (!adr_in_range(req_adr, MEM_DEPTH)) begin
            // Out-of-range ops never touch memory; stores report tag 0.
            wb_data_next = '0;
            wb_err_next  = 1'b1;
            wb_rd_next   = req_we ? '0 : req_rd;
            state_next   = RESP;
          end else begin
            state_next = req_we ? WR_ISSUE : RD_ISSUE;
          end
        end
      end
      RD_ISSUE: begin
        cnt_clear  = 1'b1;
        state_next = RD_WAIT;
      end
      RD_WAIT: begin
        cnt_en = !mem_rvalid;
        if (mem_rvalid) begin
          wb_data_next = mem_rdata;
          wb_err_next  = 1'b0;
          wb_rd_next   = rd_reg;
          state_next   = RESP;
        end else if (cnt_expired) begin
          wb_data_next = '0;
          wb_err_next  = 1'b1;
          wb_rd_next   = rd_reg;
          state_next   = RESP;
        end
      end
      WR_ISSUE: begin
        state_next = IDLE;
      end
      RESP: begin
        if (wb_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Strobes and buses are decoded from state and forced to zero when idle.
  assign req_ready = rst_n && (state_reg == IDLE);
  assign mem_rd_en = (state_reg == RD_ISSUE);
  assign mem_adr   = mem_rd_en ? adr_reg : '0;
  assign mem_we    = (state_reg == WR_ISSUE);
  assign mem_wadr  = mem_we ? adr_reg : '0;
  assign mem_wdata = mem_we ? wdata_reg : '0;
  assign wb_valid  = (state_reg == RESP);
  assign wb_data   = wb_valid ? wb_data_reg : '0;
  assign wb_rd     = wb_valid ? wb_rd_reg : '0;
  assign wb_err    = wb_valid && wb_err_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench: per-cycle expectations derived from transaction timelines.
module tb_mem_access_unit;

  localparam int MEM_DEPTH = 16;
  localparam int TIMEOUT   = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [4:0]  req_adr, req_rd;
  logic [31:0] req_wdata;
  logic        mem_rd_en, mem_we, mem_rvalid;
  logic [4:0]  mem_adr, mem_wadr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        wb_valid, wb_ready, wb_err;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;

  mem_access_unit #(.MEM_DEPTH(MEM_DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_adr(req_adr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_rd_en(mem_rd_en), .mem_adr(mem_adr), .mem_we(mem_we),
    .mem_wadr(mem_wadr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
    .wb_rd(wb_rd), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Expected outputs for the current cycle, set by the driver.
  bit          chk_en = 1'b0;
  logic        e_ready, e_rd_en, e_we, e_wb_valid, e_wb_err;
  logic [4:0]  e_adr, e_wadr, e_wb_rd;
  logic [31:0] e_wdata, e_wb_data;

  logic [31:0] mem [32];

  // Monitor bookkeeping used by the literal checks.
  int          cyc = 0;
  int          n_rd = 0, n_we = 0, n_wb = 0;
  int          wb_first_cyc = 0;
  logic        wb_valid_prev = 1'b0;
  logic [31:0] last_wb_data;
  logic [4:0]  last_wb_rd, last_wadr;
  logic        last_wb_err;

  always @(posedge clk) cyc++;

  // Compare every DUT output against the expectation for this cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      check("req_ready", req_ready, e_ready);
      check("mem_rd_en", mem_rd_en, e_rd_en);
      check("mem_adr", mem_adr, e_adr);
      check("mem_we", mem_we, e_we);
      check("mem_wadr", mem_wadr, e_wadr);
      check("mem_wdata", mem_wdata, e_wdata);
      check("wb_valid", wb_valid, e_wb_valid);
      check("wb_data", wb_data, e_wb_data);
      check("wb_rd", wb_rd, e_wb_rd);
      check("wb_err", wb_err, e_wb_err);
      check("strobe_excl", mem_rd_en & mem_we, 1'b0);
    end
  end

  // Event counters and last-handshake capture.
  always @(negedge clk) begin
    if (mem_rd_en === 1'b1) n_rd++;
    if (mem_we === 1'b1) begin n_we++; last_wadr = mem_wadr; end
    if (wb_valid === 1'b1) begin
      n_wb++;
      if (!wb_valid_prev) wb_first_cyc = cyc;
      if (wb_ready) begin
        last_wb_data = wb_data; last_wb_rd = wb_rd; last_wb_err = wb_err;
      end
    end
    wb_valid_prev = (wb_valid === 1'b1);
  end

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic drive_idle();
    req_valid  = 1'b0;
    req_we     = 1'($urandom);
    req_adr    = 5'($urandom);
    req_rd     = 5'($urandom);
    req_wdata  = $urandom;
    mem_rvalid = 1'b0;
    mem_rdata  = $urandom;
    wb_ready   = 1'b1;
  endtask

  task automatic set_idle_exp(input logic rdy);
    e_ready = rdy; e_rd_en = 0; e_adr = 0; e_we = 0; e_wadr = 0; e_wdata = 0;
    e_wb_valid = 0; e_wb_data = 0; e_wb_rd = 0; e_wb_err = 0;
  endtask

  int acc_cyc;

  // One complete operation. lat: wait cycle (1..TIMEOUT) on which read data
  // returns, 0 = never. stall: cycles wb_ready stays low in the response.
  task automatic run_op(input bit we, input logic [4:0] adr, input logic [31:0] wd,
                        input logic [4:0] rd, input int lat, input int stall, input bit stray);
    bit          inr;
    int          w;
    logic [31:0] rdata;
    logic [4:0]  rtag;
    logic        rerr;
    inr = (adr < MEM_DEPTH);
    next_cycle(); drive_idle();
    req_valid = 1'b1; req_we = we; req_adr = adr; req_wdata = wd; req_rd = rd;
    set_idle_exp(1'b1);
    acc_cyc = cyc;
    if (inr && we) begin
      next_cycle(); drive_idle(); set_idle_exp(1'b0);
      e_we = 1'b1; e_wadr = adr; e_wdata = wd;
      mem[adr] = wd;
      return;
    end
    if (inr) begin
      next_cycle(); drive_idle(); set_idle_exp(1'b0);
      e_rd_en = 1'b1; e_adr = adr;
      w = (lat == 0) ? TIMEOUT : lat;
      for (int j = 1; j <= w; j++) begin
        next_cycle(); drive_idle(); set_idle_exp(1'b0);
        if (j == lat) begin mem_rvalid = 1'b1; mem_rdata = mem[adr]; end
      end
      rdata = (lat == 0) ? 32'd0 : mem[adr];
      rerr  = (lat == 0);
      rtag  = rd;
    end else begin
      rdata = 32'd0; rerr = 1'b1; rtag = we ? 5'd0 : rd;
    end
    for (int i = 0; i <= stall; i++) begin
      next_cycle(); drive_idle();
      wb_ready = (i == stall);
      if (stray) mem_rvalid = 1'($urandom);
      set_idle_exp(1'b0);
      e_wb_valid = 1'b1; e_wb_data = rdata; e_wb_rd = rtag; e_wb_err = rerr;
    end
  endtask

  task automatic idle_cycles(input int n, input bit stray);
    for (int i = 0; i < n; i++) begin
      next_cycle(); drive_idle();
      if (stray) mem_rvalid = 1'($urandom);
      set_idle_exp(1'b1);
    end
  endtask

  int n0_rd, n0_we, n0_wb;

  task automatic snap();
    n0_rd = n_rd; n0_we = n_we; n0_wb = n_wb;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    mem[4] = 32'd10;
    rst_n = 1'b0;
    drive_idle();
    // Reset: outputs at reset values and req_ready low while rst_n is low.
    next_cycle(); drive_idle(); set_idle_exp(1'b0); chk_en = 1'b1;
    next_cycle(); drive_idle(); set_idle_exp(1'b0);
    next_cycle(); drive_idle(); rst_n = 1'b1; set_idle_exp(1'b1);
    idle_cycles(2, 1'b1);

    // Nominal load: adr 4 -> 10, tag 7, three cycles accept to wb_valid.
    snap();
    run_op(1'b0, 5'd4, 32'd0, 5'd7, 1, 0, 1'b0);
    idle_cycles(1, 1'b0);
    check("load4_data", last_wb_data, 32'd10);
    check("load4_rd", last_wb_rd, 5'd7);
    check("load4_err", last_wb_err, 1'b0);
    check("load4_latency", wb_first_cyc - acc_cyc, 3);
    check("load4_rd_pulses", n_rd - n0_rd, 1);

    // Store then load back.
    snap();
    run_op(1'b1, 5'd5, 32'hDEADBEEF, 5'd9, 1, 0, 1'b0);
    idle_cycles(1, 1'b0);
    check("store5_we_pulses", n_we - n0_we, 1);
    check("store5_wadr", last_wadr, 5'd5);
    check("store5_no_wb", n_wb - n0_wb, 0);
    run_op(1'b0, 5'd5, 32'd0, 5'd2, 2, 0, 1'b0);
    idle_cycles(1, 1'b0);
    check("load5_data", last_wb_data, 32'hDEADBEEF);

    // Out-of-range load and store.
    snap();
    run_op(1'b0, 5'd20, 32'd0, 5'd3, 1, 0, 1'b0);
    idle_cycles(1, 1'b0);
    check("oor_load_err", last_wb_err, 1'b1);
    check("oor_load_data", last_wb_data, 32'd0);
    check("oor_load_rd", last_wb_rd, 5'd3);
    run_op(1'b1, 5'd31, 32'h1234, 5'd6, 1, 0, 1'b0);
    idle_cycles(1, 1'b0);
    check("oor_store_err", last_wb_err, 1'b1);
    check("oor_store_rd", last_wb_rd, 5'd0);
    check("oor_no_strobes", (n_rd - n0_rd) + (n_we - n0_we), 0);

    // Read timeout: TIMEOUT wait cycles, then error response.
    run_op(1'b0, 5'd6, 32'd0, 5'd11, 0, 0, 1'b0);
    idle_cycles(1, 1'b0);
    check("timeout_err", last_wb_err, 1'b1);
    check("timeout_latency", wb_first_cyc - acc_cyc, TIMEOUT + 2);

    // Back-pressure: five stalled response cycles with stray read data.
    snap();
    run_op(1'b0, 5'd2, 32'd0, 5'd4, 1, 5, 1'b1);
    idle_cycles(1, 1'b1);
    check("stall_wb_cycles", n_wb - n0_wb, 6);

    // Reset while waiting for read data; late data must be ignored.
    snap();
    next_cycle(); drive_idle(); req_valid = 1'b1; req_we = 1'b0;
    req_adr = 5'd3; req_rd = 5'd9; set_idle_exp(1'b1);
    next_cycle(); drive_idle(); set_idle_exp(1'b0); e_rd_en = 1'b1; e_adr = 5'd3;
    next_cycle(); drive_idle(); set_idle_exp(1'b0);
    next_cycle(); drive_idle(); rst_n = 1'b0; set_idle_exp(1'b0);
    next_cycle(); drive_idle(); set_idle_exp(1'b0);
    next_cycle(); drive_idle(); rst_n = 1'b1; mem_rvalid = 1'b1; set_idle_exp(1'b1);
    idle_cycles(3, 1'b0);
    check("reset_no_wb", n_wb - n0_wb, 0);

    // Randomized traffic.
    for (int k = 0; k < 150; k++) begin
      int lat;
      lat = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, TIMEOUT));
      run_op(1'($urandom), 5'($urandom), $urandom, 5'($urandom), lat,
             int'($urandom_range(0, 3)), 1'($urandom));
      if ($urandom_range(0, 2) == 0) idle_cycles(int'($urandom_range(1, 3)), 1'b1);
    end
    idle_cycles(2, 1'b0);
    chk_en = 1'b0;
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
